// File: rtl/subservient_dbg_host.sv
// subservient_dbg_host: byte-stream to Wishbone debug initiator for the subservient SoC debug port.
// Define SUBSERVIENT_DBG_HOST_TIMEOUT_EN to abort a bus cycle that gets no ack within TIMEOUT cycles.
module subservient_dbg_host #(
  parameter bit DEBUG_ON_RESET = 1'b1,
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_debug_mode,
  output logic [31:0] o_wb_dbg_adr,
  output logic [31:0] o_wb_dbg_dat,
  output logic [3:0]  o_wb_dbg_sel,
  output logic        o_wb_dbg_we,
  output logic        o_wb_dbg_stb,
  input  logic [31:0] i_wb_dbg_rdt,
  input  logic        i_wb_dbg_ack
);
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;
  state_t      r_state, w_next;
  logic [1:0]  r_cnt, r_last;
  logic [31:0] r_adr, r_dat, r_resp;
  logic        r_we, r_dbg, r_live;
  logic        w_rx_fire, w_tx_fire, w_ack, w_timeout, w_last_byte, w_is_rw, w_is_mode, w_abort;

  assign o_rx_ready   = r_live & (r_state inside {S_IDLE, S_ADDR, S_DATA});
  assign o_tx_valid   = r_state == S_RESP;
  assign o_tx_data    = 8'(r_resp >> {r_cnt, 3'b000});
  assign o_debug_mode = r_dbg;
  assign o_wb_dbg_adr = r_adr;
  assign o_wb_dbg_dat = r_dat;
  assign o_wb_dbg_sel = 4'b1111;
  assign o_wb_dbg_we  = r_we;
  assign o_wb_dbg_stb = r_state == S_BUS;

  assign w_rx_fire   = i_rx_valid & o_rx_ready;
  assign w_tx_fire   = o_tx_valid & i_tx_ready;
  assign w_ack       = o_wb_dbg_stb & i_wb_dbg_ack;
  assign w_last_byte = w_rx_fire & (r_cnt == 2'd3);
  assign w_is_rw     = (i_rx_data == 8'h01) | (i_rx_data == 8'h02);
  assign w_is_mode   = (i_rx_data == 8'h03) | (i_rx_data == 8'h04);
  // a completed WRITE/READ frame outside debug mode is refused without touching the bus
  assign w_abort     = (r_state inside {S_ADDR, S_DATA}) & (w_next == S_RESP);

`ifdef SUBSERVIENT_DBG_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_tmo <= '0;
    else r_tmo <= o_wb_dbg_stb ? r_tmo + TW'(1) : '0;
  assign w_timeout = o_wb_dbg_stb & ~i_wb_dbg_ack & (r_tmo == TW'(TIMEOUT - 1));
`else
  assign w_timeout = o_wb_dbg_stb & (TIMEOUT < 0);
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = !w_rx_fire ? S_IDLE : w_is_rw ? S_ADDR : w_is_mode ? S_RESP : S_IDLE;
      S_ADDR: if (w_last_byte) w_next = r_we ? S_DATA : r_dbg ? S_BUS : S_RESP;
      S_DATA: if (w_last_byte) w_next = r_dbg ? S_BUS : S_RESP;
      S_BUS:  if (w_ack || w_timeout) w_next = S_RESP;
      S_RESP: if (w_tx_fire && r_cnt == r_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= S_IDLE;
    else r_state <= w_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_live <= 1'b0;
      r_cnt  <= 2'd0;
      r_last <= 2'd0;
      r_adr  <= '0;
      r_dat  <= '0;
      r_resp <= '0;
      r_we   <= 1'b0;
      r_dbg  <= DEBUG_ON_RESET;
    end else begin
      r_live <= 1'b1;
      r_cnt  <= (w_next != r_state) ? 2'd0 : r_cnt + {1'b0, (w_rx_fire & (r_state != S_IDLE)) | w_tx_fire};
      if (w_rx_fire && r_state == S_IDLE && w_is_rw) r_we <= i_rx_data[0];
      if (w_rx_fire && r_state == S_IDLE && w_is_mode) begin
        r_dbg  <= i_rx_data == 8'h03;
        r_resp <= {24'd0, i_rx_data};
        r_last <= 2'd0;
      end
      if (w_rx_fire && r_state == S_ADDR) r_adr <= {i_rx_data, r_adr[31:8]};
      if (w_rx_fire && r_state == S_DATA) r_dat <= {i_rx_data, r_dat[31:8]};
      if (w_abort || w_timeout) begin
        r_resp <= 32'h0000_00EE;
        r_last <= 2'd0;
      end
      if (w_ack) begin
        r_resp <= r_we ? 32'h0000_0001 : i_wb_dbg_rdt;
        r_last <= r_we ? 2'd0 : 2'd3;
      end
    end
  end
endmodule

// File: tb/tb_subservient_dbg_host.sv
// tb_subservient_dbg_host: directed vectors plus randomized frames checked against a frame-level model.
module tb_subservient_dbg_host;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0, tx_ready = 1'b0;
  logic        rx_ready, tx_valid, dbg, we, stb;
  logic [7:0]  tx_data;
  logic [31:0] adr, dat, rdt;
  logic [3:0]  sel;
  logic        ack;

  always #5 clk = ~clk;

  subservient_dbg_host #(.DEBUG_ON_RESET(1'b1), .TIMEOUT(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(rx_ready),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_debug_mode(dbg),
    .o_wb_dbg_adr(adr), .o_wb_dbg_dat(dat), .o_wb_dbg_sel(sel),
    .o_wb_dbg_we(we), .o_wb_dbg_stb(stb),
    .i_wb_dbg_rdt(rdt), .i_wb_dbg_ack(ack)
  );

`ifdef SUBSERVIENT_DBG_HOST_TIMEOUT_EN
  localparam int STALL = 6;
`else
  localparam int STALL = 20;
`endif

  typedef struct packed {
    logic [71:0] f;
    logic [3:0]  nb;
    logic [31:0] e;
    logic [2:0]  ne;
    logic        ntr;
    logic        mode;
  } vec_t;
  vec_t vecs[9];

  int errs = 0, checks = 0;
  bit [31:0] slave_mem[bit [31:0]];
  bit [31:0] model_mem[bit [31:0]];
  bit model_mode = 1'b1;
  int ack_dly = 0, inj_req = 0;
  bit slave_en = 1'b1;
  int n_trans = 0, n_acks = 0, stb_len = 0;
  bit unstable = 1'b0;
  logic [31:0] bus_adr = '0, bus_dat = '0;
  logic bus_we = 1'b0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errs++;
    $display("FAIL %s: expected event never happened", name);
  endtask

  // Wishbone memory: acks ack_dly cycles after stb rises, plus injected stray acks
  initial begin
    int cnt = 0, inj_done = 0;
    ack = 1'b0;
    rdt = '0;
    forever begin
      @(posedge clk);
      #1;
      if (ack) begin
        ack = 1'b0;
        cnt = 0;
      end else if (inj_req != inj_done) begin
        ack = 1'b1;
        inj_done++;
      end else if (stb && slave_en) begin
        if (cnt == ack_dly) begin
          ack = 1'b1;
          rdt = slave_mem.exists(adr) ? slave_mem[adr] : dflt(adr);
          if (we) slave_mem[adr] = dat;
          cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  initial begin
    bit prev = 1'b0;
    int cur = 0;
    forever begin
      @(negedge clk);
      if (stb) begin
        if (!prev) begin
          n_trans++;
          cur = 1;
          bus_adr = adr;
          bus_dat = dat;
          bus_we = we;
          unstable = (sel !== 4'hF);
        end else begin
          cur++;
          if (adr !== bus_adr || dat !== bus_dat || we !== bus_we || sel !== 4'hF) unstable = 1'b1;
        end
        if (ack) n_acks++;
      end else if (prev) stb_len = cur;
      prev = stb;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic send_frame(input logic [71:0] f, input int nb);
    int w;
    for (int i = 0; i < nb; i++) begin
      w = 0;
      rx_data = f[8*i +: 8];
      rx_valid = 1'b1;
      while (!rx_ready && w < 200) begin
        @(posedge clk);
        #1;
        w++;
      end
      if (!rx_ready) fail("rx_accept");
      else begin
        @(posedge clk);
        #1;
      end
      rx_valid = 1'b0;
    end
  endtask

  task automatic recv_all(input int ne, input int stall, output logic [31:0] got);
    int w;
    logic [7:0] b0;
    bit bad;
    got = '0;
    tx_ready = 1'b0;
    bad = 1'b0;
    if (ne == 0) begin
      for (int i = 0; i < 4; i++) begin
        if (tx_valid) bad = 1'b1;
        @(posedge clk);
        #1;
      end
      chk("no_resp", {31'd0, bad}, 0);
      chk("idle_after_drop", {31'd0, rx_ready}, 1);
      return;
    end
    w = 0;
    while (!tx_valid && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!tx_valid) begin
      fail("tx_valid");
      return;
    end
    b0 = tx_data;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      if (!tx_valid || tx_data !== b0) bad = 1'b1;
    end
    if (stall > 0) chk("tx_hold", {31'd0, bad}, 0);
    tx_ready = 1'b1;
    for (int i = 0; i < ne; i++) begin
      if (!tx_valid) begin
        fail("tx_back_to_back");
        break;
      end
      got[8*i +: 8] = tx_data;
      @(posedge clk);
      #1;
    end
    tx_ready = 1'b0;
    chk("tx_len", {31'd0, tx_valid}, 0);
    chk("back_to_idle", {31'd0, rx_ready}, 1);
  endtask

  // frame-level reference: what the host must answer and whether a bus cycle happens
  task automatic model(input logic [71:0] f, output logic [31:0] e, output int ne, output bit ntr);
    logic [7:0] cmd;
    logic [31:0] a, d;
    cmd = f[7:0];
    a = f[39:8];
    d = f[71:40];
    e = '0;
    ne = 0;
    ntr = 1'b0;
    if (cmd == 8'h01 || cmd == 8'h02) begin
      ntr = model_mode;
      ne = (model_mode && cmd == 8'h02) ? 4 : 1;
      e = !model_mode ? 32'hEE : cmd == 8'h01 ? 32'h01 : model_mem.exists(a) ? model_mem[a] : dflt(a);
      if (model_mode && cmd == 8'h01) model_mem[a] = d;
    end else if (cmd == 8'h03 || cmd == 8'h04) begin
      model_mode = cmd == 8'h03;
      e = {24'd0, cmd};
      ne = 1;
    end
  endtask

  task automatic bus_chk(input string tag, input logic [71:0] f);
    chk({tag, "_bus_adr"}, bus_adr, f[39:8]);
    chk({tag, "_bus_we"}, {31'd0, bus_we}, {31'd0, f[7:0] == 8'h01});
    if (f[7:0] == 8'h01) chk({tag, "_bus_dat"}, bus_dat, f[71:40]);
    chk({tag, "_bus_stable"}, {31'd0, unstable}, 0);
  endtask

  task automatic mexec(input logic [71:0] f, input int nb, input int stall, input string tag);
    logic [31:0] e, got;
    int ne, n0;
    bit ntr;
    model(f, e, ne, ntr);
    n0 = n_trans;
    send_frame(f, nb);
    recv_all(ne, stall, got);
    chk({tag, "_resp"}, got, e);
    chk({tag, "_trans"}, n_trans - n0, {31'd0, ntr});
    chk({tag, "_mode"}, {31'd0, dbg}, {31'd0, model_mode});
    if (ntr) begin
      bus_chk(tag, f);
      chk({tag, "_stb_len"}, stb_len, ack_dly + 1);
    end
  endtask

  task automatic stray_ack(input string tag);
    bit bad;
    int n0;
    n0 = n_trans;
    bad = 1'b0;
    inj_req++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (tx_valid || stb) bad = 1'b1;
    end
    chk({tag, "_ignored"}, {31'd0, bad}, 0);
    chk({tag, "_idle"}, {31'd0, rx_ready}, 1);
    chk({tag, "_trans"}, n_trans - n0, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 0);
    chk({tag, "_tx_valid"}, {31'd0, tx_valid}, 0);
    chk({tag, "_tx_data"}, {24'd0, tx_data}, 0);
    chk({tag, "_stb"}, {31'd0, stb}, 0);
    chk({tag, "_we"}, {31'd0, we}, 0);
    chk({tag, "_adr"}, adr, 0);
    chk({tag, "_dat"}, dat, 0);
    chk({tag, "_sel"}, {28'd0, sel}, 32'hF);
    chk({tag, "_mode"}, {31'd0, dbg}, 1);
  endtask

  initial begin
    logic [71:0] f;
    logic [31:0] e, got;
    int ne, n0, a0, w, r, nb;
    bit ntr, bad;
    logic [7:0] cmd;

    vecs[0] = '{{32'h0, 32'h10, 8'h02}, 4'd5, 32'hDEADBEEF, 3'd4, 1'b1, 1'b1};
    vecs[1] = '{{32'h0, 32'h0, 8'h04}, 4'd1, 32'h04, 3'd1, 1'b0, 1'b0};
    vecs[2] = '{{32'h44332211, 32'h0, 8'h01}, 4'd9, 32'hEE, 3'd1, 1'b0, 1'b0};
    vecs[3] = '{{32'h0, 32'h0, 8'h02}, 4'd5, 32'hEE, 3'd1, 1'b0, 1'b0};
    vecs[4] = '{{32'h0, 32'h0, 8'h7F}, 4'd1, 32'h0, 3'd0, 1'b0, 1'b0};
    vecs[5] = '{{32'h0, 32'h0, 8'h03}, 4'd1, 32'h03, 3'd1, 1'b0, 1'b1};
    vecs[6] = '{{32'h0, 32'h0, 8'h02}, 4'd5, 32'hA5A55A5A, 3'd4, 1'b1, 1'b1};
    vecs[7] = '{{32'hCAFEF00D, 32'h8, 8'h01}, 4'd9, 32'h01, 3'd1, 1'b1, 1'b1};
    vecs[8] = '{{32'h0, 32'h8, 8'h02}, 4'd5, 32'hCAFEF00D, 3'd4, 1'b1, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rx_ready_after_reset", {31'd0, rx_ready}, 1);

    f = {32'hDEADBEEF, 32'h10, 8'h01};
    model(f, e, ne, ntr);
    n0 = n_trans;
    send_frame(f, 9);
    chk("t1_stb_latency", {31'd0, stb}, 1);
    @(posedge clk);
    #1;
    chk("t1_ack_to_tx", {31'd0, tx_valid}, 1);
    recv_all(ne, 0, got);
    chk("t1_resp", got, 32'h01);
    chk("t1_trans", n_trans - n0, 1);
    chk("t1_stb_len", stb_len, 1);
    bus_chk("t1", f);

    for (int i = 0; i < 9; i++) begin
      model(vecs[i].f, e, ne, ntr);
      n0 = n_trans;
      send_frame(vecs[i].f, int'(vecs[i].nb));
      recv_all(int'(vecs[i].ne), i % 3, got);
      chk($sformatf("vec%0d_resp", i), got, vecs[i].e);
      chk($sformatf("vec%0d_trans", i), n_trans - n0, {31'd0, vecs[i].ntr});
      chk($sformatf("vec%0d_mode", i), {31'd0, dbg}, {31'd0, vecs[i].mode});
    end

    slave_mem[32'h10] = 32'h12345678;
    model_mem[32'h10] = 32'h12345678;
    f = {32'h0, 32'h10, 8'h02};
    model(f, e, ne, ntr);
    send_frame(f, 5);
    recv_all(4, 5, got);
    chk("t2_read_lsb_first", got, 32'h12345678);

    stray_ack("idle_ack");

    ack_dly = STALL;
    f = {32'h55667788, 32'h40, 8'h01};
    model(f, e, ne, ntr);
    n0 = n_trans;
    a0 = n_acks;
    send_frame(f, 9);
    rx_data = 8'h55;
    rx_valid = 1'b1;
    bad = 1'b0;
    w = 0;
    while (!tx_valid && w < 200) begin
      if (rx_ready) bad = 1'b1;
      @(posedge clk);
      #1;
      w++;
    end
    rx_valid = 1'b0;
    chk("t4_rx_ready_busy", {31'd0, bad}, 0);
    recv_all(1, 0, got);
    chk("t4_resp", got, 32'h01);
    chk("t4_stb_len", stb_len, STALL + 1);
    chk("t4_one_ack", n_acks - a0, 1);
    chk("t4_trans", n_trans - n0, 1);
    bus_chk("t4", f);
    ack_dly = 0;
    mexec({32'h0, 32'h0, 8'h7F}, 1, 0, "t4_unknown");
    mexec({32'h0, 32'h40, 8'h02}, 5, 1, "t4_after");

    ack_dly = 50;
    send_frame({32'h0, 32'h40, 8'h02}, 5);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("t5_midbus");
    @(negedge clk);
    rst_n = 1'b1;
    model_mode = 1'b1;
    ack_dly = 2;
    @(posedge clk);
    #1;
    mexec({32'h0, 32'h40, 8'h02}, 5, 0, "t5_read");

`ifdef SUBSERVIENT_DBG_HOST_TIMEOUT_EN
    slave_en = 1'b0;
    n0 = n_trans;
    a0 = n_acks;
    send_frame({32'h0, 32'h40, 8'h02}, 5);
    recv_all(1, 0, got);
    chk("t6_resp", got, 32'hEE);
    chk("t6_stb_len", stb_len, 8);
    chk("t6_trans", n_trans - n0, 1);
    chk("t6_no_ack", n_acks - a0, 0);
    stray_ack("t6_late_ack");
    slave_en = 1'b1;
`endif

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 11);
      cmd = r < 4 ? 8'h01 : r < 8 ? 8'h02 : r < 10 ? 8'h03 : r == 10 ? 8'h04 : 8'h00;
      if (r == 11) begin
        cmd = 8'($urandom_range(5, 255));
        if ($urandom_range(0, 3) == 0) cmd = 8'h00;
      end
      nb = cmd == 8'h01 ? 9 : cmd == 8'h02 ? 5 : 1;
      f = {32'($urandom), 32'h100 + 32'($urandom_range(0, 7) * 4), cmd};
      ack_dly = $urandom_range(0, 4);
      mexec(f, nb, $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
